fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch stage directly downstream of the PC register.
- Takes the current PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry queue and presents them to decode with a valid/ready handshake.
- Back-pressures the PC register through pc_advance; supports flush on taken branch/jump.

Parameters:
- ADDRESS_WIDTH, 32, width of PC and memory address
- DATA_WIDTH, 32, instruction width
- DEPTH, 4, queue entries; power of two, >= 2

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-low (rst=0 resets)
- pc_in  input  ADDRESS_WIDTH  current PC from PC register
- pc_advance  output  1  request accepted this cycle; PC register may update
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  ADDRESS_WIDTH  fetch address, equals pc_in
- imem_req_ready  input  1  memory accepts request
- imem_rsp_valid  input  1  response valid; responses in order, latency >= 1 cycle
- imem_rsp_data  input  DATA_WIDTH  instruction word
- flush  input  1  discard all queued and in-flight fetches
- dec_valid  output  1  head entry holds an instruction
- dec_instr  output  DATA_WIDTH  head instruction
- dec_pc  output  ADDRESS_WIDTH  PC of head instruction
- dec_ready  input  1  decode consumes head
- occupancy  output  $clog2(DEPTH+1)  allocated entries (filled + awaiting data)

Behaviour:
- Reset (rst=0, async):
  - Pointers, occupancy, drop_cnt and all entry valid/filled bits clear.
  - dec_valid=0, imem_req_valid=0, pc_advance=0.
  - dec_instr/dec_pc read 0.
- Entry state: allocated (PC stored, awaiting data) -> filled (data stored) -> freed on pop.
- Three pointers (alloc, fill, head) wrap modulo DEPTH.
- Request issue:
  - imem_req_valid = (occupancy < DEPTH) & !flush & rst.
  - imem_req_addr = pc_in (combinational).
  - On handshake (valid & ready): allocate entry at alloc pointer with pc_in; alloc pointer +1; pc_advance=1 in the same cycle.
- Response:
  - If drop_cnt > 0: response discarded, drop_cnt -1.
  - Otherwise: data written to the entry at the fill pointer, marked filled, fill pointer +1.
  - A response with nothing outstanding is a protocol error: ignored, and the bench asserts.
- Decode output:
  - dec_valid = head entry filled (registered state, no combinational path from imem_rsp_*).
  - Latency: response in cycle N -> dec_valid in cycle N+1.
  - Pop on dec_valid & dec_ready: head pointer +1, occupancy -1.
- occupancy:
  - +1 on request handshake, -1 on pop; both in one cycle -> unchanged.
  - Request is blocked only when occupancy==DEPTH at the start of the cycle; a same-cycle pop does not free a slot for a same-cycle request.
- Flush (highest priority):
  - In the flush cycle: no request issued, any pop ignored, any response counted as dropped.
  - Next cycle: all entries invalid, pointers 0, occupancy 0.
  - drop_cnt <= (allocated-unfilled entries) - (1 if a response arrived in the flush cycle and drop_cnt was 0) + (old drop_cnt, less 1 if a response consumed it).
  - Requests may issue from the cycle after flush while drop_cnt > 0; in-order responses drain drop_cnt first.
- Bounds:
  - drop_cnt <= DEPTH (width $clog2(DEPTH+1)).
  - Total in-flight requests never exceed 2*DEPTH.
- Full queue: imem_req_valid=0, pc_advance=0; PC register holds.
- Empty queue: dec_valid=0 and dec_instr/dec_pc are don't-care.
- Reset mid-operation: asynchronous clear, identical to power-on reset. Memory responses arriving after reset release are ignored; the memory is reset by the same rst.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0], reset to 0.
  - Increments each cycle dec_ready=1 & dec_valid=0 & flush=0; saturates at 32'hFFFF_FFFF.
  - Cleared only by reset.
- Undefined: port and counter absent; other behaviour identical.

Test Plan:
- Memory latency 1, dec_ready=1, pc_in steps 0x0,0x4,0x8: dec_pc 0x0/0x4/0x8 with matching instrs, each 2 cycles after request; pc_advance=1 every cycle.
- dec_ready=0, memory always ready, DEPTH=4: exactly 4 requests (0x0..0xC) accepted; then imem_req_valid=0, pc_advance=0, occupancy=4. dec_ready=1 for one cycle -> pop 0x0, next request 0x10 issues the following cycle.
- Latency 3, 3 requests in flight, flush asserted, pc_in=0x100 next cycle: 3 stale responses dropped. First dec_valid shows dec_pc=0x100 with the response for 0x100.
- Flush in the same cycle as a response and a dec pop: pop ignored, response dropped, occupancy=0 next cycle, dec_valid=0.
- rst=0 asserted asynchronously mid-stream with 2 filled entries: dec_valid, imem_req_valid and occupancy go 0 immediately without a clock edge. After release, fetch restarts from the current pc_in.
- With FETCH_STALL_CNT_EN: dec_ready=1, memory latency 4 from reset, single request -> stall_cnt=5 when first dec_valid rises.

Source files
------------

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - handshake bundle between fetch_queue, instruction memory and decode
//
// Signals:
//   imem_req_valid / imem_req_addr / imem_req_ready : fetch request channel (queue -> memory)
//   imem_rsp_valid / imem_rsp_data                  : in-order response channel (memory -> queue), no back-pressure
//   dec_valid / dec_instr / dec_pc / dec_ready      : decode channel (queue -> decode)
// Modports:
//   master : the fetch queue side
//   slave  : the environment side (memory plus decode)
`timescale 1ns/1ps

interface fetch_queue_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     imem_req_valid;
    logic [ADDRESS_WIDTH-1:0] imem_req_addr;
    logic                     imem_req_ready;
    logic                     imem_rsp_valid;
    logic [DATA_WIDTH-1:0]    imem_rsp_data;
    logic                     dec_valid;
    logic [DATA_WIDTH-1:0]    dec_instr;
    logic [ADDRESS_WIDTH-1:0] dec_pc;
    logic                     dec_ready;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output dec_valid,
        output dec_instr,
        output dec_pc,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  dec_valid,
        input  dec_instr,
        input  dec_pc,
        output dec_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction fetch queue between the PC register and decode
//
// Ports:
//   clk        : single clock, rising edge
//   rst        : asynchronous active-low reset
//   pc_in      : current PC, driven straight out as the fetch address
//   pc_advance : a fetch request was accepted this cycle; the PC register may step
//   flush      : discard all queued and in-flight fetches (taken branch/jump)
//   bus        : fetch_queue_if.master carrying the memory request/response and decode channels
//   occupancy  : allocated entries (filled plus awaiting data)
//   stall_cnt  : cycles decode was ready but had nothing to take (only with FETCH_STALL_CNT_EN)
//
// Optional feature macro: FETCH_STALL_CNT_EN
//
// Each entry is allocated when its request is accepted (PC captured), filled when its
// response returns, and freed when decode pops it. Three pointers walk the ring:
// alloc (next request), fill (oldest entry still waiting for data), head (decode side).
`timescale 1ns/1ps

module fetch_queue #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDRESS_WIDTH-1:0]   pc_in,
    output logic                       pc_advance,
    input  logic                       flush,
    fetch_queue_if.master              bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    // Entry storage
    logic [ADDRESS_WIDTH-1:0] entry_pc   [DEPTH];
    logic [DATA_WIDTH-1:0]    entry_data [DEPTH];
    logic [DEPTH-1:0]         entry_filled;

    // Ring pointers and counters
    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] head_ptr;
    logic [OCC_W-1:0] occ_q;       // allocated entries
    logic [OCC_W-1:0] unfilled_q;  // allocated entries still waiting for their response
    logic [OCC_W-1:0] drop_cnt;    // responses still owed to fetches killed by a flush

    logic             req_valid;
    logic             req_fire;
    logic             rsp_drop;
    logic             rsp_claim;
    logic             rsp_fill;
    logic             head_filled;
    logic             pop;
    logic [OCC_W-1:0] flush_drop;

    // Request side. The full check uses the start-of-cycle occupancy, so a
    // pop in the same cycle never frees a slot for a same-cycle request.
    assign req_valid = (occ_q < DEPTH_OCC) & ~flush & rst;
    assign req_fire  = req_valid & bus.imem_req_ready;

    // Response side. Responses owed to killed fetches come back first, so they
    // are peeled off by drop_cnt before any live entry is filled. A response
    // with neither a drop owed nor a live entry waiting is ignored.
    assign rsp_drop  = bus.imem_rsp_valid & (drop_cnt != '0);
    assign rsp_claim = bus.imem_rsp_valid & (drop_cnt == '0) & (unfilled_q != '0);
    assign rsp_fill  = rsp_claim & ~flush;

    // Decode side; dec_valid comes only from registered state.
    assign head_filled = entry_filled[head_ptr];
    assign pop         = head_filled & bus.dec_ready & ~flush;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_in;
    assign pc_advance         = req_fire;
    assign bus.dec_valid      = head_filled;
    assign bus.dec_instr      = entry_data[head_ptr];
    assign bus.dec_pc         = entry_pc[head_ptr];
    assign occupancy          = occ_q;

    // On flush every unfilled entry becomes a response to throw away, on top of
    // those already owed. A response landing in the flush cycle pays one off,
    // whether it was an old stale one or the reply for a now-killed entry.
    always_comb begin
        flush_drop = unfilled_q + drop_cnt;
        if (rsp_claim | rsp_drop) begin
            flush_drop = flush_drop - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_ptr    <= '0;
            fill_ptr     <= '0;
            head_ptr     <= '0;
            occ_q        <= '0;
            unfilled_q   <= '0;
            drop_cnt     <= '0;
            entry_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_pc[i]   <= '0;
                entry_data[i] <= '0;
            end
        end else if (flush) begin
            alloc_ptr    <= '0;
            fill_ptr     <= '0;
            head_ptr     <= '0;
            occ_q        <= '0;
            unfilled_q   <= '0;
            entry_filled <= '0;
            drop_cnt     <= flush_drop;
        end else begin
            if (req_fire) begin
                entry_pc[alloc_ptr] <= pc_in;
                alloc_ptr           <= alloc_ptr + PTR_W'(1);
            end

            if (rsp_drop) begin
                drop_cnt <= drop_cnt - OCC_W'(1);
            end

            // fill_ptr never points at the head entry being popped: the head
            // is already filled, fill_ptr sits on the oldest unfilled entry.
            if (rsp_fill) begin
                entry_data[fill_ptr]   <= bus.imem_rsp_data;
                entry_filled[fill_ptr] <= 1'b1;
                fill_ptr               <= fill_ptr + PTR_W'(1);
            end

            if (pop) begin
                entry_filled[head_ptr] <= 1'b0;
                head_ptr               <= head_ptr + PTR_W'(1);
            end

            case ({req_fire, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase

            case ({req_fire, rsp_fill})
                2'b10:   unfilled_q <= unfilled_q + OCC_W'(1);
                2'b01:   unfilled_q <= unfilled_q - OCC_W'(1);
                default: unfilled_q <= unfilled_q;
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Counts decode starvation; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (bus.dec_ready & ~head_filled & ~flush & (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with memory, PC and decode models
`timescale 1ns/1ps

module tb_fetch_queue;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_in;
    logic          pc_advance;
    logic          flush;
    logic [OW-1:0] occupancy;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    fetch_queue_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fetch_queue #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_advance (pc_advance),
        .flush      (flush),
        .bus        (bus),
        .occupancy  (occupancy)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: queue of allocated entries in program order
    typedef struct {
        logic [AW-1:0] pc;
        bit            filled;
        logic [DW-1:0] data;
    } ent_t;
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } mreq_t;

    ent_t          mq[$];
    mreq_t         memq[$];
    int            drop_m;
    logic [31:0]   stall_m;
    logic [AW-1:0] pc_reg;
    int            cyc;

    // Stimulus knobs
    int            lat_min, lat_max, ready_pct, dec_pct, flush_pct;
    bit            req_gate;
    bit            force_flush;
    logic [AW-1:0] flush_target;

    // Per-cycle values
    bit            e_req_valid, e_fire, e_dec_valid, e_pop;
    logic          rdy, dr, rsp_v;
    logic [DW-1:0] rsp_d;
    logic [AW-1:0] obs_pop_pc[$];
    logic [DW-1:0] obs_pop_instr[$];
    int            adv_cnt;
    bit            found;

    int checks   = 0;
    int failures = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        flush              = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.dec_ready      = 1'b0;
    endtask

    task automatic model_clear();
        mq.delete();
        memq.delete();
        drop_m  = 0;
        stall_m = '0;
        cyc     = 0;
    endtask

    task automatic do_reset(input logic [AW-1:0] start_pc);
        rst = 1'b0;
        idle_inputs();
        bus.imem_req_ready = 1'b1;
        pc_reg = start_pc;
        pc_in  = start_pc;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dec_valid", bus.dec_valid, 1'b0);
        chk("rst_req_valid", bus.imem_req_valid, 1'b0);
        chk("rst_pc_advance", pc_advance, 1'b0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_dec_pc", bus.dec_pc, 0);
        chk("rst_dec_instr", bus.dec_instr, 0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        bus.imem_req_ready = 1'b0;
        rst = 1'b1;
    endtask

    task automatic cyc_begin();
        @(posedge clk);
        #1;
        cyc++;
        pc_in = pc_reg;
        if (force_flush) begin
            flush = 1'b1;
        end else if (($urandom_range(99) < flush_pct) && (drop_m == 0)) begin
            flush        = 1'b1;
            flush_target = $urandom & 32'hFFFF_FFFC;
        end else begin
            flush = 1'b0;
        end
        force_flush = 1'b0;
        rdy = req_gate && ($urandom_range(99) < ready_pct);
        dr  = ($urandom_range(99) < dec_pct);
        bus.imem_req_ready = rdy;
        bus.dec_ready      = dr;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            rsp_v = 1'b1;
            rsp_d = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            rsp_v = 1'b0;
            rsp_d = $urandom;
        end
        bus.imem_rsp_valid = rsp_v;
        bus.imem_rsp_data  = rsp_d;
        #1;
        e_req_valid = (mq.size() < DEPTH) && !flush;
        e_fire      = e_req_valid && rdy;
        e_dec_valid = (mq.size() > 0) && mq[0].filled;
        e_pop       = e_dec_valid && dr && !flush;
        chk("imem_req_valid", bus.imem_req_valid, e_req_valid);
        chk("imem_req_addr", bus.imem_req_addr, pc_reg);
        chk("pc_advance", pc_advance, e_fire);
        chk("occupancy", occupancy, mq.size());
        chk("dec_valid", bus.dec_valid, e_dec_valid);
        if (e_dec_valid) begin
            chk("dec_pc", bus.dec_pc, mq[0].pc);
            chk("dec_instr", bus.dec_instr, mq[0].data);
        end
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stall_m);
`endif
        if (pc_advance) adv_cnt++;
        if (bus.dec_valid && dr && !flush) begin
            obs_pop_pc.push_back(bus.dec_pc);
            obs_pop_instr.push_back(bus.dec_instr);
        end
    endtask

    task automatic cyc_end();
        int   unf;
        int   fi;
        ent_t e;
        if (dr && !e_dec_valid && !flush && stall_m != 32'hFFFF_FFFF) stall_m++;
        if (flush) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            if (rsp_v) begin
                if (drop_m > 0) drop_m--;
                else if (unf > 0) unf--;
            end
            drop_m += unf;
            mq.delete();
            pc_reg = flush_target;
        end else begin
            if (rsp_v) begin
                if (drop_m > 0) begin
                    drop_m--;
                end else begin
                    fi = -1;
                    foreach (mq[i]) if (!mq[i].filled && fi < 0) fi = i;
                    chk("rsp_outstanding", fi >= 0, 1'b1);
                    if (fi >= 0) begin
                        mq[fi].filled = 1'b1;
                        mq[fi].data   = rsp_d;
                    end
                end
            end
            if (e_pop) void'(mq.pop_front());
            if (e_fire) begin
                e.pc     = pc_in;
                e.filled = 1'b0;
                e.data   = '0;
                mq.push_back(e);
                memq.push_back('{addr: pc_in, due: cyc + int'($urandom_range(lat_max, lat_min))});
                pc_reg = pc_reg + 32'd4;
            end
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            cyc_begin();
            cyc_end();
        end
    endtask

    task automatic knobs(input int lmin, input int lmax, input int rp, input int dp);
        lat_min   = lmin;
        lat_max   = lmax;
        ready_pct = rp;
        dec_pct   = dp;
        flush_pct = 0;
        req_gate  = 1'b1;
        adv_cnt   = 0;
        obs_pop_pc.delete();
        obs_pop_instr.delete();
    endtask

    initial begin
        force_flush  = 1'b0;
        flush_target = '0;
        knobs(1, 1, 100, 100);

        // Latency 1, decode always ready: steady one-per-cycle stream
        do_reset(32'h0);
        knobs(1, 1, 100, 100);
        step(5);
        chk("tp1_advances", adv_cnt, 5);
        chk("tp1_pops", obs_pop_pc.size(), 3);
        if (obs_pop_pc.size() >= 3) begin
            chk("tp1_pc0", obs_pop_pc[0], 32'h0);
            chk("tp1_pc1", obs_pop_pc[1], 32'h4);
            chk("tp1_pc2", obs_pop_pc[2], 32'h8);
            chk("tp1_instr1", obs_pop_instr[1], mem_word(32'h4));
        end

        // Decode stalled: queue fills at DEPTH, then one pop frees a slot a cycle later
        do_reset(32'h0);
        knobs(1, 1, 100, 0);
        step(5);
        chk("tp2_accepted", adv_cnt, 4);
        cyc_begin();
        chk("tp2_full_req_valid", bus.imem_req_valid, 1'b0);
        chk("tp2_full_pc_advance", pc_advance, 1'b0);
        chk("tp2_full_occupancy", occupancy, 4);
        cyc_end();
        dec_pct = 100;
        cyc_begin();
        chk("tp2_pop_pc", bus.dec_pc, 32'h0);
        chk("tp2_pop_cycle_req_valid", bus.imem_req_valid, 1'b0);
        cyc_end();
        dec_pct = 0;
        cyc_begin();
        chk("tp2_next_req_valid", bus.imem_req_valid, 1'b1);
        chk("tp2_next_req_addr", bus.imem_req_addr, 32'h10);
        chk("tp2_next_advance", pc_advance, 1'b1);
        cyc_end();

        // Latency 3, flush with three fetches in flight, redirect to 0x100
        do_reset(32'h0);
        knobs(3, 3, 100, 100);
        step(3);
        force_flush  = 1'b1;
        flush_target = 32'h100;
        step(1);
        obs_pop_pc.delete();
        obs_pop_instr.delete();
        step(8);
        chk("tp3_has_pop", obs_pop_pc.size() > 0, 1'b1);
        if (obs_pop_pc.size() > 0) begin
            chk("tp3_first_pc", obs_pop_pc[0], 32'h100);
            chk("tp3_first_instr", obs_pop_instr[0], mem_word(32'h100));
        end

        // Flush colliding with a response and a decode pop
        do_reset(32'h0);
        knobs(1, 1, 100, 100);
        step(2);
        force_flush  = 1'b1;
        flush_target = 32'h40;
        cyc_begin();
        chk("tp4_dec_valid_in_flush", bus.dec_valid, 1'b1);
        chk("tp4_rsp_in_flush", rsp_v, 1'b1);
        cyc_end();
        cyc_begin();
        chk("tp4_occ_after", occupancy, 0);
        chk("tp4_dec_valid_after", bus.dec_valid, 1'b0);
        cyc_end();
        obs_pop_pc.delete();
        step(4);
        chk("tp4_resume_pop", obs_pop_pc.size() > 0, 1'b1);
        if (obs_pop_pc.size() > 0) chk("tp4_resume_pc", obs_pop_pc[0], 32'h40);

        // Asynchronous reset with two filled entries
        do_reset(32'h0);
        knobs(1, 1, 100, 0);
        step(2);
        req_gate = 1'b0;
        step(2);
        chk("tp5_pre_occupancy", occupancy, 2);
        chk("tp5_pre_dec_valid", bus.dec_valid, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk("tp5_async_dec_valid", bus.dec_valid, 1'b0);
        chk("tp5_async_req_valid", bus.imem_req_valid, 1'b0);
        chk("tp5_async_occupancy", occupancy, 0);
        idle_inputs();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_gate = 1'b1;
        cyc_begin();
        chk("tp5_restart_valid", bus.imem_req_valid, 1'b1);
        chk("tp5_restart_addr", bus.imem_req_addr, 32'h8);
        chk("tp5_restart_advance", pc_advance, 1'b1);
        cyc_end();
        step(4);

`ifdef FETCH_STALL_CNT_EN
        // Single fetch at latency 4 with decode waiting from reset
        do_reset(32'h0);
        knobs(4, 4, 100, 100);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            cyc_begin();
            req_gate = 1'b0;
            if (bus.dec_valid) begin
                chk("tp6_stall_cnt", stall_cnt, 5);
                found = 1'b1;
            end
            cyc_end();
        end
        chk("tp6_dec_valid_seen", found, 1'b1);
`endif

        // Randomized traffic with flushes, variable latency and back-pressure
        do_reset(32'h1000);
        knobs(1, 5, 70, 60);
        flush_pct = 3;
        step(3000);
        knobs(1, 2, 95, 20);
        flush_pct = 2;
        step(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
